shr_seq: RTL and testbench

SHR_SEQ -- requirements
Module: shr_seq

---
 rtl/shr_seq.sv | 114 +++++++++++
 tb/tb_shr_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/shr_seq.sv
`default_nettype none
// ============================================================================
//  Module   : shr_seq
//  Purpose  : Iterative right shifter. It moves one bit position per clock and
//             fills with zero (logical) or the captured sign bit (arithmetic).
//  Options  : SHR_SEQ_ROTATE_EN adds the 'rot' input for rotate-right
//             operation. When rot is set it takes priority over arith.
//  Revision : 1.0  initial release
// ============================================================================
module shr_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [3:0]       cnt,
  input  logic             arith,
`ifdef SHR_SEQ_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [3:0]       cnt_q,   cnt_d;
  // Fill bit for arithmetic mode. It is the captured in[MSB] when arith=1,
  // otherwise 0. Because it is captured, later changes to in cannot affect it.
  logic             sign_q,  sign_d;
  logic             w_fill;

`ifdef SHR_SEQ_ROTATE_EN
  logic             rot_q,   rot_d;

  // Rotate feeds the outgoing LSB back in at the top. It overrides arith.
  always_comb w_fill = rot_q ? out_q[0] : sign_q;
`else
  // Fill bit for the vacated MSB on each shift step.
  always_comb w_fill = sign_q;
`endif

  // Next-state logic: capture on an accepted start, then one shift per edge.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
`ifdef SHR_SEQ_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      c_IDLE: begin
        if (start) begin
          out_d  = in;
          cnt_d  = cnt;
          sign_d = arith & in[WIDTH-1];
`ifdef SHR_SEQ_ROTATE_EN
          rot_d  = rot;
`endif
          // A zero-length shift goes straight to DONE with out = in.
          state_d = (cnt == 4'd0) ? c_DONE : c_SHIFT;
        end
      end
      c_SHIFT: begin
        out_d = {w_fill, out_q[WIDTH-1:1]};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = c_DONE;
        end
      end
      c_DONE: begin
        // A start that arrives in this cycle is dropped.
        state_d = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // State registers. The asynchronous reset aborts any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
      out_q   <= '0;
      cnt_q   <= 4'd0;
      sign_q  <= 1'b0;
`ifdef SHR_SEQ_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
`ifdef SHR_SEQ_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign out  = out_q;
  assign busy = (state_q == c_SHIFT);
  assign done = (state_q == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_shr_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shr_seq
//  Purpose  : Directed self-checking bench for shr_seq. Stimulus is driven and
//             outputs are sampled on the falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shr_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] tb_in;
  logic [3:0]  tb_cnt;
  logic        tb_arith;
  logic        tb_rot;
  logic [15:0] out;
  logic        busy;
  logic        done;

  int n_assert;
  int n_fail;

  shr_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (tb_in),
    .cnt   (tb_cnt),
    .arith (tb_arith),
`ifdef SHR_SEQ_ROTATE_EN
    .rot   (tb_rot),
`endif
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and watch it to completion and four cycles beyond.
  // When inj is nonzero, a competing start is pulsed in that cycle. Cycle k
  // is the k-th falling edge after the accepting rising edge.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [3:0] c,
                        input logic ar, input logic [15:0] exp, input int inj);
    int busy_n;
    int done_n;
    int done_k;
    busy_n = 0;
    done_n = 0;
    done_k = -1;
    @(negedge clk);
    start    = 1'b1;
    tb_in    = a;
    tb_cnt   = c;
    tb_arith = ar;
    for (int k = 1; k <= int'(c) + 5; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        done_n++;
        done_k = k;
      end
      // Scramble the operands after capture. They must not matter.
      start    = 1'b0;
      tb_in    = ~a;
      tb_cnt   = ~c;
      tb_arith = ~ar;
      if (k == inj) begin
        start    = 1'b1;
        tb_in    = 16'hAAAA;
        tb_cnt   = 4'd0;
        tb_arith = 1'b1;
      end
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, done_k, int'(c) + 1);
    chk({tag, "_done_count"}, done_n, 1);
    chk({tag, "_busy_cycles"}, busy_n, int'(c));
    chk({tag, "_out"}, out, exp);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    tb_in    = 16'h0;
    tb_cnt   = 4'd0;
    tb_arith = 1'b0;
    tb_rot   = 1'b0;

    // Check the reset state.
    repeat (2) @(negedge clk);
    chk("rst_out", out, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;

    // Basic logical and arithmetic shifts.
    run_op("b5a0_l4",  16'hB5A0, 4'd4,  1'b0, 16'h0B5A, 0);
    run_op("8001_a15", 16'h8001, 4'd15, 1'b1, 16'hFFFF, 0);
    run_op("8001_l15", 16'h8001, 4'd15, 1'b0, 16'h0001, 0);
    run_op("1234_c0",  16'h1234, 4'd0,  1'b0, 16'h1234, 0);
    run_op("b5a0_a4",  16'hB5A0, 4'd4,  1'b1, 16'hFB5A, 0);
    run_op("7fff_a3",  16'h7FFF, 4'd3,  1'b1, 16'h0FFF, 0);
    run_op("c003_l1",  16'hC003, 4'd1,  1'b0, 16'h6001, 0);

    // A start while busy must be ignored.
    run_op("f0f0_busy_start", 16'hF0F0, 4'd6, 1'b0, 16'h03C3, 2);
    // A start during the done cycle must be ignored.
    run_op("f0f0_done_start", 16'hF0F0, 4'd6, 1'b1, 16'hFFC3, 7);
    run_op("c0_done_start",   16'h1234, 4'd0, 1'b0, 16'h1234, 1);

    // Reset in the middle of SHIFT aborts the operation without a done pulse.
    @(negedge clk);
    start    = 1'b1;
    tb_in    = 16'hFFFF;
    tb_cnt   = 4'd8;
    tb_arith = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out", out, 16'h0000);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done === 1'b1 || busy === 1'b1) seen++;
      end
      chk("abort_no_done", seen, 0);
    end
    run_op("after_abort", 16'hB5A0, 4'd4, 1'b0, 16'h0B5A, 0);

`ifdef SHR_SEQ_ROTATE_EN
    tb_rot = 1'b1;
    run_op("rot_0003_1", 16'h0003, 4'd1, 1'b0, 16'h8001, 0);
    run_op("rot_1234_4", 16'h1234, 4'd4, 1'b1, 16'h4123, 0);
    tb_rot = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
